card_dealer: RTL and testbench
==============================

// Module: card_dealer
// PURPOSE
//  Consumes the 1..13 card rank stream from the LFSR random source and deals cards on request.
//  Tracks how many copies of each rank remain in the shoe and redraws when a rank is exhausted.
//  Keeps one player hand: hard sum, soft/hard ace total, bust and blackjack flags.
//  Sits between the random source and the game FSM; one instance per hand (player, dealer).
// PARAMETERS
//  DECKS      1   number of 52-card decks in the shoe; each rank starts with 4*DECKS copies
//  MAX_CARDS  11  max cards per hand; deal_req is ignored once card_cnt == MAX_CARDS
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous active-high reset
//  rnd         in   4   rank from random source; valid ranks 1..13, any other value is treated as invalid
//  deal_req    in   1   request one card; sampled only in IDLE
//  new_hand    in   1   clear hand state; shoe is kept
//  shuffle     in   1   refill shoe to 4*DECKS per rank and clear hand
//  busy        out  1   high while state != IDLE
//  card_valid  out  1   one-cycle pulse: card_rank/card_value hold the newly dealt card
//  card_rank   out  4   dealt rank 1..13 (1=A, 11=J, 12=Q, 13=K); held until next deal
//  card_value  out  4   1 for A, 2..10 face value, 10 for J/Q/K
//  card_cnt    out  4   cards in current hand
//  hand_total  out  5   best total: hard_sum+10 if ace held and hard_sum<=11, else hard_sum
//  hand_soft   out  1   ace currently counted as 11
//  hand_bust   out  1   hand_total > 21
//  hand_bj     out  1   card_cnt==2 and hand_total==21
//  deck_left   out  $clog2(52*DECKS+1)  cards remaining in shoe
//  deck_empty  out  1   deck_left == 0
// BEHAVIOUR
//  Reset: state IDLE; all rank counters = 4*DECKS; deck_left = 52*DECKS; every other output 0.
//  FSM IDLE -> DRAW when deal_req && !hand_bust && card_cnt<MAX_CARDS && !deck_empty; otherwise deal_req is dropped.
//  DRAW, every cycle: sample rnd. Accept if 1<=rnd<=13 and the count for that rank is >0;
//   on accept, the rank count and deck_left decrement, the hand updates, and state goes to IDLE.
//   Otherwise stay in DRAW and retry next cycle. No card is consumed on retry.
//  Latency: deal_req high at edge N -> DRAW from N; earliest accept at edge N+1;
//   card_valid is high in the cycle after the accept edge, for exactly one cycle.
//  At the accept edge card_rank, card_value, card_cnt, hand_total and all flags update together (registered).
//  hard_sum is internal, 5 bits, ace counted as 1; the ace_held flag is set by any ace.
//  Worst case hard_sum = 21+10 = 31, which fits 5 bits. No saturation is needed.
//  hand_bust high blocks further deals until new_hand or shuffle.
//  new_hand, in any state: next state IDLE; hard_sum, ace_held, card_cnt, flags and card_rank/value cleared.
//   If a DRAW is pending it is aborted with no card consumed and no card_valid. The shoe is untouched.
//  shuffle: same as new_hand, and all rank counters and deck_left are reloaded.
//  Priority in one cycle: rst > shuffle > new_hand > accept/deal_req.
//   deal_req in the same cycle as new_hand is dropped.
//  deck_empty prevents DRAW entry, so DRAW always has at least one acceptable rank.
//   The random source period covers all of 1..13, so DRAW terminates.
//  busy = (state==DRAW). deal_req while busy is ignored; requests are not queued.
// TESTING
//  1 Reset, then check outputs: deck_left=52, card_cnt=0, hand_total=0, busy=0, card_valid=0, counts all 4.
//  2 Force rnd=1 then rnd=13 on two deals -> first: total 11, soft=1. Second: total 21, soft=1, bj=1, card_cnt=2, deck_left=50.
//  3 Force ranks 10,6,9 -> totals 10,16,25. bust=1 after third. A fourth deal_req gives no busy and no card_valid.
//  4 DECKS=1: deal four aces across hands using new_hand, then hold rnd=1 for 20 cycles -> busy stays 1, no card_valid.
//    Switch rnd to 5 -> accepted next edge, card_value=5.
//  5 Hold rnd=0/14/15 during DRAW -> no accept. Then raise new_hand mid-DRAW -> IDLE next cycle, no card_valid, deck_left unchanged.
//  6 Assert shuffle after 30 dealt cards -> deck_left=52, all hand outputs 0. Same-cycle deal_req is dropped.

Source files
------------

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - shoe-tracking card dealer with single-hand scoring
module card_dealer #(
  parameter  int DECKS     = 1,
  parameter  int MAX_CARDS = 11,
  localparam int DLW       = $clog2(52 * DECKS + 1),
  localparam int CW        = $clog2(4 * DECKS + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [3:0]     rnd_i,
  input  logic           deal_req_i,
  input  logic           new_hand_i,
  input  logic           shuffle_i,
  output logic           busy_o,
  output logic           card_valid_o,
  output logic [3:0]     card_rank_o,
  output logic [3:0]     card_value_o,
  output logic [3:0]     card_cnt_o,
  output logic [4:0]     hand_total_o,
  output logic           hand_soft_o,
  output logic           hand_bust_o,
  output logic           hand_bj_o,
  output logic [DLW-1:0] deck_left_o,
  output logic           deck_empty_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_t;

  localparam logic [CW-1:0]  RANK_FULL = CW'(4 * DECKS);
  localparam logic [DLW-1:0] SHOE_FULL = DLW'(52 * DECKS);
  localparam logic [3:0]     MAX_CNT   = 4'(MAX_CARDS);

  state_t         state_q;
  logic [CW-1:0]  rank_left_q [13];
  logic [DLW-1:0] deck_left_q;
  logic [4:0]     hard_sum_q;
  logic           ace_held_q;
  logic [3:0]     card_cnt_q;
  logic           card_valid_q;
  logic [3:0]     card_rank_q;
  logic [3:0]     card_value_q;
  logic [4:0]     hand_total_q;
  logic           hand_soft_q;
  logic           hand_bust_q;
  logic           hand_bj_q;

  logic           rank_ok;
  logic           accept;
  logic           draw_start;
  logic [3:0]     value_d;
  logic [4:0]     hard_sum_d;
  logic           ace_held_d;
  logic           soft_d;
  logic [4:0]     total_d;
  logic [3:0]     card_cnt_d;
  logic           bust_d;
  logic           bj_d;

  // Candidate card evaluation: is rnd a rank still in the shoe, and what the hand becomes if it is taken.
  always_comb begin
    rank_ok = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (rnd_i == 4'(i + 1) && rank_left_q[i] != '0) begin
        rank_ok = 1'b1;
      end
    end
    accept     = (state_q == ST_DRAW) && rank_ok;
    draw_start = (state_q == ST_IDLE) && deal_req_i && !hand_bust_q &&
                 (card_cnt_q < MAX_CNT) && (deck_left_q != '0);
    value_d    = (rnd_i >= 4'd10) ? 4'd10 : rnd_i;
    // The ace is always summed as 1 here; the +10 upgrade is decided from the new hard sum.
    hard_sum_d = hard_sum_q + {1'b0, value_d};
    ace_held_d = ace_held_q | (rnd_i == 4'd1);
    soft_d     = ace_held_d && (hard_sum_d <= 5'd11);
    total_d    = soft_d ? (hard_sum_d + 5'd10) : hard_sum_d;
    card_cnt_d = card_cnt_q + 4'd1;
    bust_d     = total_d > 5'd21;
    bj_d       = (card_cnt_d == 4'd2) && (total_d == 5'd21);
  end

  // Dealer FSM plus shoe and hand registers; reset/shuffle/new_hand override any draw in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i || shuffle_i || new_hand_i) begin
      state_q      <= ST_IDLE;
      card_valid_q <= 1'b0;
      card_rank_q  <= 4'd0;
      card_value_q <= 4'd0;
      card_cnt_q   <= 4'd0;
      hard_sum_q   <= 5'd0;
      ace_held_q   <= 1'b0;
      hand_total_q <= 5'd0;
      hand_soft_q  <= 1'b0;
      hand_bust_q  <= 1'b0;
      hand_bj_q    <= 1'b0;
      if (rst_i || shuffle_i) begin
        deck_left_q <= SHOE_FULL;
        for (int i = 0; i < 13; i++) begin
          rank_left_q[i] <= RANK_FULL;
        end
      end
    end else begin
      card_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (draw_start) begin
            state_q <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          // A rejected rnd leaves everything untouched; the next cycle simply tries again.
          if (accept) begin
            state_q      <= ST_IDLE;
            card_valid_q <= 1'b1;
            card_rank_q  <= rnd_i;
            card_value_q <= value_d;
            card_cnt_q   <= card_cnt_d;
            hard_sum_q   <= hard_sum_d;
            ace_held_q   <= ace_held_d;
            hand_total_q <= total_d;
            hand_soft_q  <= soft_d;
            hand_bust_q  <= bust_d;
            hand_bj_q    <= bj_d;
            deck_left_q  <= deck_left_q - DLW'(1);
            for (int i = 0; i < 13; i++) begin
              if (rnd_i == 4'(i + 1)) begin
                rank_left_q[i] <= rank_left_q[i] - CW'(1);
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q == ST_DRAW);
  assign card_valid_o = card_valid_q;
  assign card_rank_o  = card_rank_q;
  assign card_value_o = card_value_q;
  assign card_cnt_o   = card_cnt_q;
  assign hand_total_o = hand_total_q;
  assign hand_soft_o  = hand_soft_q;
  assign hand_bust_o  = hand_bust_q;
  assign hand_bj_o    = hand_bj_q;
  assign deck_left_o  = deck_left_q;
  assign deck_empty_o = (deck_left_q == '0);

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - randomized self-checking bench for card_dealer
module tb_card_dealer;

  localparam int MAX_CARDS = 11;
  localparam int DLW       = $clog2(53);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     rnd = 4'd0;
  logic           deal_req = 1'b0;
  logic           new_hand = 1'b0;
  logic           shuffle = 1'b0;
  logic           busy;
  logic           card_valid;
  logic [3:0]     card_rank;
  logic [3:0]     card_value;
  logic [3:0]     card_cnt;
  logic [4:0]     hand_total;
  logic           hand_soft;
  logic           hand_bust;
  logic           hand_bj;
  logic [DLW-1:0] deck_left;
  logic           deck_empty;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining copies per rank, shoe size, and the list of ranks in the hand.
  int rem [13];
  int deck;
  int hand[$];
  int last_rank;

  card_dealer #(.DECKS(1), .MAX_CARDS(MAX_CARDS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rnd_i        (rnd),
    .deal_req_i   (deal_req),
    .new_hand_i   (new_hand),
    .shuffle_i    (shuffle),
    .busy_o       (busy),
    .card_valid_o (card_valid),
    .card_rank_o  (card_rank),
    .card_value_o (card_value),
    .card_cnt_o   (card_cnt),
    .hand_total_o (hand_total),
    .hand_soft_o  (hand_soft),
    .hand_bust_o  (hand_bust),
    .hand_bj_o    (hand_bj),
    .deck_left_o  (deck_left),
    .deck_empty_o (deck_empty)
  );

  always #5 clk = ~clk;

  function automatic int val_of(input int r);
    return (r >= 10) ? 10 : r;
  endfunction

  function automatic int m_hard();
    int s = 0;
    foreach (hand[k]) s += val_of(hand[k]);
    return s;
  endfunction

  function automatic bit m_soft();
    bit ace = 1'b0;
    foreach (hand[k]) if (hand[k] == 1) ace = 1'b1;
    return ace && (m_hard() + 10 <= 21);
  endfunction

  function automatic int m_total();
    return m_soft() ? m_hard() + 10 : m_hard();
  endfunction

  function automatic bit m_bust();
    return m_total() > 21;
  endfunction

  function automatic bit m_bj();
    return (hand.size() == 2) && (m_total() == 21);
  endfunction

  function automatic void m_refill();
    foreach (rem[k]) rem[k] = 4;
    deck = 52;
    hand.delete();
    last_rank = 0;
  endfunction

  function automatic void m_clear_hand();
    hand.delete();
    last_rank = 0;
  endfunction

  // One deal request; forced < 0 picks random rnd values (valid and invalid) until one is acceptable.
  task automatic deal_card(input int forced);
    bit enter;
    bit acc;
    bit done;
    int r;
    int cyc;
    enter = !m_bust() && (hand.size() < MAX_CARDS) && (deck > 0);
    @(negedge clk);
    deal_req = 1'b1;
    rnd = 4'($urandom_range(0, 15));
    @(negedge clk);
    deal_req = 1'b0;
    checks++;
    if (busy !== enter) begin
      errors++;
      $display("FAIL deal_enter busy=%0b expected=%0b", busy, enter);
    end
    checks++;
    if (card_valid !== 1'b0) begin
      errors++;
      $display("FAIL deal_early_valid card_valid=%0b expected=0", card_valid);
    end
    if (enter) begin
      done = 1'b0;
      cyc = 0;
      while (!done) begin
        if (forced >= 0) begin
          r = forced;
        end else if (cyc < 64) begin
          r = int'($urandom_range(0, 15));
        end else begin
          r = 0;
          for (int k = 12; k >= 0; k--) if (rem[k] > 0) r = k + 1;
        end
        rnd = 4'(r);
        acc = (r >= 1) && (r <= 13) && (rem[(r >= 1 && r <= 13) ? r - 1 : 0] > 0);
        @(negedge clk);
        checks++;
        if (card_valid !== acc) begin
          errors++;
          $display("FAIL draw_valid rnd=%0d card_valid=%0b expected=%0b", r, card_valid, acc);
        end
        if (acc) begin
          rem[r - 1]--;
          deck--;
          hand.push_back(r);
          last_rank = r;
          done = 1'b1;
          checks++;
          if (card_rank !== 4'(r)) begin
            errors++;
            $display("FAIL card_rank got=%0d expected=%0d", card_rank, r);
          end
          checks++;
          if (card_value !== 4'(val_of(r))) begin
            errors++;
            $display("FAIL card_value got=%0d expected=%0d", card_value, val_of(r));
          end
          checks++;
          if (card_cnt !== 4'(hand.size())) begin
            errors++;
            $display("FAIL card_cnt got=%0d expected=%0d", card_cnt, hand.size());
          end
          checks++;
          if (hand_total !== 5'(m_total())) begin
            errors++;
            $display("FAIL hand_total got=%0d expected=%0d", hand_total, m_total());
          end
          checks++;
          if ({hand_soft, hand_bust, hand_bj} !== {m_soft(), m_bust(), m_bj()}) begin
            errors++;
            $display("FAIL hand_flags soft/bust/bj got=%b%b%b expected=%b%b%b",
                     hand_soft, hand_bust, hand_bj, m_soft(), m_bust(), m_bj());
          end
          checks++;
          if (deck_left !== DLW'(deck) || deck_empty !== (deck == 0)) begin
            errors++;
            $display("FAIL deck_left got=%0d/%0b expected=%0d/%0b", deck_left, deck_empty, deck, deck == 0);
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept busy=%0b expected=0", busy);
          end
        end else begin
          cyc++;
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_retry busy=%0b expected=1", busy);
          end
          if (cyc > 200) begin
            errors++;
            $display("FAIL deal_timeout cycles=%0d expected_accept_by=200", cyc);
            done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic pulse_new_hand();
    @(negedge clk);
    new_hand = 1'b1;
    @(negedge clk);
    new_hand = 1'b0;
    m_clear_hand();
    checks++;
    if (card_cnt !== 4'd0 || hand_total !== 5'd0 || card_rank !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL new_hand_clear cnt=%0d total=%0d rank=%0d busy=%0b expected=0/0/0/0",
               card_cnt, hand_total, card_rank, busy);
    end
    checks++;
    if (deck_left !== DLW'(deck)) begin
      errors++;
      $display("FAIL new_hand_shoe deck_left=%0d expected=%0d", deck_left, deck);
    end
  endtask

  task automatic pulse_shuffle();
    @(negedge clk);
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    m_refill();
    checks++;
    if (deck_left !== DLW'(52) || card_cnt !== 4'd0) begin
      errors++;
      $display("FAIL shuffle_reload deck_left=%0d cnt=%0d expected=52/0", deck_left, card_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_refill();
    checks++;
    if (deck_left !== DLW'(52) || deck_empty !== 1'b0) begin
      errors++;
      $display("FAIL reset_deck deck_left=%0d empty=%0b expected=52/0", deck_left, deck_empty);
    end
    checks++;
    if (card_cnt !== 4'd0 || hand_total !== 5'd0 || card_rank !== 4'd0 || card_value !== 4'd0) begin
      errors++;
      $display("FAIL reset_hand cnt=%0d total=%0d rank=%0d value=%0d expected=0", card_cnt, hand_total,
               card_rank, card_value);
    end
    checks++;
    if ({busy, card_valid, hand_soft, hand_bust, hand_bj} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags busy/valid/soft/bust/bj=%b%b%b%b%b expected=00000",
               busy, card_valid, hand_soft, hand_bust, hand_bj);
    end
  endtask

  task automatic test_ace_blackjack();
    deal_card(1);
    checks++;
    if (hand_total !== 5'd11 || hand_soft !== 1'b1) begin
      errors++;
      $display("FAIL ace_first total=%0d soft=%0b expected=11/1", hand_total, hand_soft);
    end
    deal_card(13);
    checks++;
    if (hand_total !== 5'd21 || hand_soft !== 1'b1 || hand_bj !== 1'b1 || card_cnt !== 4'd2 ||
        deck_left !== DLW'(50)) begin
      errors++;
      $display("FAIL blackjack total=%0d soft=%0b bj=%0b cnt=%0d deck=%0d expected=21/1/1/2/50",
               hand_total, hand_soft, hand_bj, card_cnt, deck_left);
    end
  endtask

  task automatic test_bust();
    pulse_new_hand();
    deal_card(10);
    deal_card(6);
    checks++;
    if (hand_total !== 5'd16 || hand_bust !== 1'b0) begin
      errors++;
      $display("FAIL bust_pre total=%0d bust=%0b expected=16/0", hand_total, hand_bust);
    end
    deal_card(9);
    checks++;
    if (hand_total !== 5'd25 || hand_bust !== 1'b1) begin
      errors++;
      $display("FAIL bust_set total=%0d bust=%0b expected=25/1", hand_total, hand_bust);
    end
    deal_card(-1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || card_valid !== 1'b0 || card_cnt !== 4'd3) begin
      errors++;
      $display("FAIL bust_block busy=%0b valid=%0b cnt=%0d expected=0/0/3", busy, card_valid, card_cnt);
    end
  endtask

  task automatic test_exhausted_rank();
    pulse_shuffle();
    for (int k = 0; k < 4; k++) begin
      deal_card(1);
      pulse_new_hand();
    end
    @(negedge clk);
    deal_req = 1'b1;
    rnd = 4'd1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || card_valid !== 1'b0) begin
        errors++;
        $display("FAIL exhausted_hold cycle=%0d busy=%0b valid=%0b expected=1/0", k, busy, card_valid);
      end
    end
    rnd = 4'd5;
    deal_req = 1'b0;
    @(negedge clk);
    rem[4]--;
    deck--;
    hand.push_back(5);
    checks++;
    if (card_valid !== 1'b1 || card_value !== 4'd5 || card_rank !== 4'd5 || deck_left !== DLW'(deck)) begin
      errors++;
      $display("FAIL exhausted_switch valid=%0b value=%0d rank=%0d deck=%0d expected=1/5/5/%0d",
               card_valid, card_value, card_rank, deck_left, deck);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || card_valid !== 1'b0 || card_cnt !== 4'd1) begin
      errors++;
      $display("FAIL exhausted_single busy=%0b valid=%0b cnt=%0d expected=0/0/1", busy, card_valid, card_cnt);
    end
  endtask

  task automatic test_invalid_abort();
    int bad [3] = '{0, 14, 15};
    @(negedge clk);
    deal_req = 1'b1;
    rnd = 4'd0;
    @(negedge clk);
    deal_req = 1'b0;
    for (int k = 0; k < 9; k++) begin
      rnd = 4'(bad[k % 3]);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || card_valid !== 1'b0) begin
        errors++;
        $display("FAIL invalid_rank rnd=%0d busy=%0b valid=%0b expected=1/0", bad[k % 3], busy, card_valid);
      end
    end
    rnd = 4'd7;
    new_hand = 1'b1;
    @(negedge clk);
    new_hand = 1'b0;
    m_clear_hand();
    checks++;
    if (busy !== 1'b0 || card_valid !== 1'b0 || deck_left !== DLW'(deck) || card_cnt !== 4'd0) begin
      errors++;
      $display("FAIL abort_draw busy=%0b valid=%0b deck=%0d cnt=%0d expected=0/0/%0d/0",
               busy, card_valid, deck_left, card_cnt, deck);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || card_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet busy=%0b valid=%0b expected=0/0", busy, card_valid);
    end
  endtask

  task automatic test_shuffle_after_30();
    pulse_shuffle();
    for (int n = 0; n < 30; n++) begin
      if (m_bust() || hand.size() == MAX_CARDS || (hand.size() > 0 && $urandom_range(0, 3) == 0)) begin
        pulse_new_hand();
      end
      deal_card(-1);
    end
    checks++;
    if (deck_left !== DLW'(22) || deck != 22) begin
      errors++;
      $display("FAIL thirty_dealt deck_left=%0d model=%0d expected=22", deck_left, deck);
    end
    @(negedge clk);
    shuffle = 1'b1;
    deal_req = 1'b1;
    rnd = 4'd5;
    @(negedge clk);
    shuffle = 1'b0;
    deal_req = 1'b0;
    m_refill();
    checks++;
    if (deck_left !== DLW'(52) || card_cnt !== 4'd0 || hand_total !== 5'd0 || card_rank !== 4'd0 ||
        card_value !== 4'd0) begin
      errors++;
      $display("FAIL shuffle_clear deck=%0d cnt=%0d total=%0d rank=%0d value=%0d expected=52/0/0/0/0",
               deck_left, card_cnt, hand_total, card_rank, card_value);
    end
    checks++;
    if ({busy, card_valid, hand_soft, hand_bust, hand_bj} !== 5'b0) begin
      errors++;
      $display("FAIL shuffle_flags busy/valid/soft/bust/bj=%b%b%b%b%b expected=00000",
               busy, card_valid, hand_soft, hand_bust, hand_bj);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || card_valid !== 1'b0) begin
      errors++;
      $display("FAIL shuffle_drops_deal busy=%0b valid=%0b expected=0/0", busy, card_valid);
    end
    deal_card(-1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ace_blackjack();
    test_bust();
    test_exhausted_rank();
    test_invalid_abort();
    test_shuffle_after_30();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
